// File: rtl/upc_checkout_ctrl.sv
// Checkout-lane scan sequencer: latches UPC/mark, evaluates sale/stolen,
// counts items and raises a theft alarm. Optional macro: ALARM_BLINK_EN.
module upc_checkout_ctrl #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_btn,
  input  logic             clear,
  input  logic             mark,
  input  logic [2:0]       UPC,
  output logic [2:0]       upc_q,
  output logic             sale,
  output logic             stolen,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] sale_cnt
);

  localparam int TMR_W = $clog2(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, EVAL, HOLD, ALARM} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scan_sync, clr_sync;
  logic                   scan_prev, scan_pulse, clear_s;
  logic                   mark_q, alarm_r;
  logic [TMR_W-1:0]       timer;
  logic                   sale_calc, stolen_calc, tmr_zero, clear_abort;

  assign clear_s     = clr_sync[SYNC_STAGES-1];
  assign sale_calc   = upc_q[1] | (upc_q[2] & upc_q[0]);
  assign stolen_calc = ~mark_q & ~upc_q[1] & (upc_q[2] | ~upc_q[0]);
  assign tmr_zero    = (timer == '0);
  assign clear_abort = clear_s && (state != ALARM);

  // Input synchronizers; the edge detect is registered so each press yields one pulse.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_sync  <= '0;
      clr_sync   <= '0;
      scan_prev  <= 1'b0;
      scan_pulse <= 1'b0;
    end else begin
      scan_sync  <= {scan_sync[SYNC_STAGES-2:0], scan_btn};
      clr_sync   <= {clr_sync[SYNC_STAGES-2:0], clear};
      scan_prev  <= scan_sync[SYNC_STAGES-1];
      scan_pulse <= scan_sync[SYNC_STAGES-1] & ~scan_prev;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!clear_s && scan_pulse) state_n = CAPTURE;
      CAPTURE: state_n = clear_s ? IDLE : EVAL;
      EVAL:    if (clear_s)          state_n = IDLE;
               else if (stolen_calc) state_n = ALARM;
               else                  state_n = HOLD;
      HOLD:    if (clear_s || tmr_zero) state_n = IDLE;
      ALARM:   if (clear_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    alarm = alarm_r;
  end

  // Datapath: latch, evaluate, count, time. clear outside ALARM beats everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q    <= '0;
      mark_q   <= 1'b0;
      sale     <= 1'b0;
      stolen   <= 1'b0;
      alarm_r  <= 1'b0;
      item_cnt <= '0;
      sale_cnt <= '0;
      timer    <= '0;
    end else if (clear_abort) begin
      item_cnt <= '0;
      sale_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (scan_pulse) begin
          upc_q  <= UPC;
          mark_q <= mark;
        end
        EVAL: begin
          sale   <= sale_calc;
          stolen <= stolen_calc;
          if (stolen_calc) begin
            alarm_r <= 1'b1;
`ifdef ALARM_BLINK_EN
            timer   <= TMR_LOAD;
`endif
          end else begin
            timer <= TMR_LOAD;
            if (item_cnt != '1)              item_cnt <= item_cnt + 1'b1;
            if (sale_calc && sale_cnt != '1) sale_cnt <= sale_cnt + 1'b1;
          end
        end
        HOLD: if (!tmr_zero) timer <= timer - 1'b1;
        ALARM: begin
          if (clear_s) alarm_r <= 1'b0;
`ifdef ALARM_BLINK_EN
          else if (tmr_zero) begin
            timer   <= TMR_LOAD;
            alarm_r <= ~alarm_r;
          end else timer <= timer - 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Randomized bench for upc_checkout_ctrl against a transaction-level model;
// a second instance with CNT_W=2 exercises counter saturation.
`timescale 1ns/1ps
module tb_upc_checkout_ctrl;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset, scan_btn, clear, mark;
  logic [2:0] UPC;
  logic [2:0] upc_q, upc_q2;
  logic       sale, stolen, alarm, busy, sale2, stolen2, alarm2, busy2;
  logic [7:0] item_cnt, sale_cnt;
  logic [1:0] item_cnt2, sale_cnt2;

  always #5 clk = ~clk;

  upc_checkout_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scan_btn(scan_btn), .clear(clear), .mark(mark), .UPC(UPC),
    .upc_q(upc_q), .sale(sale), .stolen(stolen), .alarm(alarm), .busy(busy),
    .item_cnt(item_cnt), .sale_cnt(sale_cnt));

  upc_checkout_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .scan_btn(scan_btn), .clear(clear), .mark(mark), .UPC(UPC),
    .upc_q(upc_q2), .sale(sale2), .stolen(stolen2), .alarm(alarm2), .busy(busy2),
    .item_cnt(item_cnt2), .sale_cnt(sale_cnt2));

  int n_checks = 0;
  int n_fail   = 0;
  int item_m   = 0;
  int sale_m   = 0;
  logic [2:0] last_u = 3'd0;
  logic [7:0] sale_tab   = 8'hEC;  // codes 2,3,5,6,7 are on sale
  logic [7:0] stolen_tab = 8'h31;  // codes 0,4,5 are stolen when unmarked

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "/item"},  32'(item_cnt),  sat(item_m, 255));
    check({tag, "/sale"},  32'(sale_cnt),  sat(sale_m, 255));
    check({tag, "/item2"}, 32'(item_cnt2), sat(item_m, 3));
    check({tag, "/sale2"}, 32'(sale_cnt2), sat(sale_m, 3));
  endtask

  // One press; k counts falling edges after the press is driven.
  task automatic scan(input logic [2:0] u, input logic m, input int held, input bit extra);
    bit exp_sale, exp_stolen;
    int busy_n, total;
    exp_sale   = sale_tab[u];
    exp_stolen = !m && stolen_tab[u];
    total      = (held + 3 > 12) ? held + 3 : 12;
    busy_n     = 0;
    @(negedge clk);
    UPC = u; mark = m; scan_btn = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 3) check("pre_busy", 32'(busy), 32'd0);
      if (k == 4) begin
        check("upc_q", 32'(upc_q), 32'(u));
        check("cap_busy", 32'(busy), 32'd1);
        UPC  = 3'($urandom);
        mark = 1'($urandom);
      end
      if (k == 6) begin
        if (!exp_stolen) begin
          item_m++;
          if (exp_sale) sale_m++;
        end
        check("sale", 32'(sale), 32'(exp_sale));
        check("stolen", 32'(stolen), 32'(exp_stolen));
        if (!exp_stolen) check("alarm_off", 32'(alarm), 32'd0);
        check_counts("eval");
      end
      if (!exp_stolen && k >= 4 && busy) busy_n++;
      if (exp_stolen && k >= 6) begin
        check("alarm_busy", 32'(busy), 32'd1);
`ifdef ALARM_BLINK_EN
        check("alarm_blink", 32'(alarm), 32'((((k - 6) / HOLD) % 2) == 0));
`else
        check("alarm_on", 32'(alarm), 32'd1);
`endif
      end
      scan_btn = (k < held) || (extra && (k == 4 || k == 5));
    end
    last_u = u;
    if (!exp_stolen) begin
      check("busy_len", busy_n, HOLD + 2);
      check("idle", 32'(busy), 32'd0);
    end
    check_counts("post");
  endtask

  task automatic do_clear(input bit in_alarm);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (2) @(negedge clk);
    if (!in_alarm) begin
      item_m = 0;
      sale_m = 0;
    end
    check("clr_alarm", 32'(alarm), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_upc_held", 32'(upc_q), 32'(last_u));
    check_counts("clr");
    repeat (2) @(negedge clk);
  endtask

  task automatic press_in_alarm;
    @(negedge clk); scan_btn = 1'b1; UPC = 3'($urandom); mark = 1'($urandom);
    repeat (3) @(negedge clk);
    scan_btn = 1'b0;
    repeat (6) @(negedge clk);
    check("alarm_hold_busy", 32'(busy), 32'd1);
    check("alarm_hold_upc", 32'(upc_q), 32'(last_u));
    check("alarm_hold_stolen", 32'(stolen), 32'd1);
    check_counts("alarm_hold");
  endtask

  initial begin
    reset = 1'b1; scan_btn = 1'b0; clear = 1'b0; mark = 1'b0; UPC = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({upc_q, sale, stolen, alarm, busy}), 32'd0);
    check_counts("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Good sale item, then a press held 100 cycles and one with a re-press during HOLD.
    scan(3'b010, 1'b0, 2, 1'b0);
    scan(3'b100, 1'b1, 3, 1'b0);
    scan(3'b011, 1'b0, 100, 1'b0);
    scan(3'b110, 1'b0, 1, 1'b1);

    // Theft: second press ignored, clear returns to IDLE with counters kept.
    scan(3'b000, 1'b0, 2, 1'b0);
    press_in_alarm();
    do_clear(1'b1);

    // clear outside ALARM aborts HOLD, zeroes counters, holds results.
    @(negedge clk); UPC = 3'b111; mark = 1'b0; scan_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) scan_btn = 1'b0;
      if (k == 6) clear = 1'b1;
      if (k == 7) clear = 1'b0;
      if (k == 9) begin
        item_m = 0; sale_m = 0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sale_held", 32'(sale), 32'd1);
        check("abort_upc_held", 32'(upc_q), 32'd7);
        check_counts("abort");
      end
    end
    last_u = 3'b111;

    // clear and scan pulse reach IDLE in the same cycle: scan dropped.
    scan(3'b010, 1'b0, 2, 1'b0);
    @(negedge clk); UPC = 3'b101; scan_btn = 1'b1;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) scan_btn = 1'b0;
      if (k == 4 || k == 8) check("clr_scan_busy", 32'(busy), 32'd0);
    end
    item_m = 0; sale_m = 0;
    check("clr_scan_upc", 32'(upc_q), 32'(last_u));
    check_counts("clr_scan");

    // Saturation of the CNT_W=2 instance.
    for (int i = 0; i < 6; i++) scan(3'b010, 1'b0, 1, 1'b0);
    check("sat_item2", 32'(item_cnt2), 32'd3);
    check("sat_sale2", 32'(sale_cnt2), 32'd3);

    // Reset in the middle of HOLD.
    @(negedge clk); UPC = 3'b010; mark = 1'b0; scan_btn = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    item_m = 0; sale_m = 0; last_u = 3'd0;
    check("midreset_outs", 32'({upc_q, sale, stolen, alarm, busy}), 32'd0);
    check_counts("midreset");
    @(negedge clk); reset = 1'b0; scan_btn = 1'b0;
    repeat (3) @(negedge clk);
    scan(3'b010, 1'b0, 2, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      logic [2:0] u;
      logic       m;
      int         held;
      bit         extra;
      u     = 3'($urandom_range(0, 7));
      m     = 1'($urandom_range(0, 1));
      held  = $urandom_range(1, 4);
      extra = (held <= 2) && ($urandom_range(0, 1) == 1);
      scan(u, m, held, extra);
      if (!m && stolen_tab[u]) begin
        if ($urandom_range(0, 1) == 1) press_in_alarm();
        do_clear(1'b1);
      end else if ($urandom_range(0, 5) == 0) begin
        do_clear(1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
